uart_tx_ctrl: RTL
=================

# uart_tx_ctrl

Memory-mapped UART transmit controller for the dual-issue RV32I core. It sits behind the two memory stages. The core's data-memory decoders assert a byte-write strobe on either lane when a store targets the UART data address. The controller accepts up to two bytes per cycle in program order (lane 1 older than lane 2) and buffers them in a FIFO. It then serializes them as 8N1 frames onto `uart_tx`. When the buffer cannot guarantee room for a full dual-issue pair, it raises a stall request to the pipeline.

## Interface
Parameters:
- `CLK_PER_BIT`, default 868: clock cycles per UART bit; legal range 2 and above.
- `FIFO_DEPTH`, default 16: byte buffer entries; must be a power of two, 4 or more.

Ports:
- `CLK`, input, 1: the single clock; all state changes on its rising edge.
- `RST`, input, 1: reset, synchronous and active-high.
- `wen1`, input, 1: lane-1 (older instruction) byte store to the UART.
- `wdata1`, input, 8: lane-1 byte.
- `wen2`, input, 1: lane-2 (younger instruction) byte store to the UART.
- `wdata2`, input, 8: lane-2 byte.
- `stall`, output, 1: pipeline hold request; high when free entries are fewer than 2.
- `busy`, output, 1: high while a frame is on the line or the FIFO is non-empty.
- `overflow`, output, 1: sticky flag, set when a byte is dropped; cleared only by `RST`.
- `count`, output, clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `uart_tx`, output, 1: serial line, idle high.

## Operation
- **Reset values:** `uart_tx`=1, `stall`=0, `busy`=0, `overflow`=0, `count`=0. The FSM is IDLE and the FIFO is empty.
- **Push rules:**
  - Acceptance is judged against the registered `count` at the edge. A pop in the same cycle gives no credit.
  - `wen1` alone: push `wdata1` if `count` < DEPTH.
  - `wen2` alone: push `wdata2` under the same rule.
  - Both strobes: push `wdata1` then `wdata2` if `count` ≤ DEPTH-2.
  - Both strobes with exactly one slot free: push `wdata1` only, drop `wdata2`, set `overflow`.
  - Any strobe with the FIFO full: drop the byte(s) and set `overflow`.
- **Stall:** `stall` = (`count` ≥ DEPTH-1), registered from the next `count`. Stores issued while `stall` is high are still honoured by the push rules above.
- **FSM states:**
  - IDLE: `uart_tx`=1. If FIFO non-empty, pop the head into the shift register and go to START.
  - START: `uart_tx`=0 for CLK_PER_BIT cycles, then go to DATA.
  - DATA: drive `shift[0]` (LSB first) for CLK_PER_BIT cycles, then shift right. After 8 bits, go to STOP.
  - STOP: `uart_tx`=1 for CLK_PER_BIT cycles. Then, if FIFO non-empty, pop and go directly to START with no idle cycle; otherwise go to IDLE.
- **Counters:**
  - Baud counter is clog2(CLK_PER_BIT) bits. It loads 0 on every state entry and wraps at CLK_PER_BIT-1.
  - Bit index is 3 bits and wraps from 7 to 0 on leaving DATA.
- **Pointers:** FIFO pointers are clog2(DEPTH)+1 bits with natural wrap. Full/empty are decided by the MSB compare.
- **Simultaneous push and pop:** `count` += pushes − pop, all in one edge.
- **Reset mid-frame:** the frame is aborted; `uart_tx` returns high at the reset edge and the FIFO contents are discarded.

## Timing
- A write accepted at edge N: if the FIFO was empty and the FSM idle, the pop happens at edge N+1 and `uart_tx` falls at edge N+1.
- Frame length: exactly 10×CLK_PER_BIT cycles.
- Back-to-back frames: the next start bit begins on the cycle after the last stop-bit cycle.
- `stall` and `count` reflect the edge's pushes and pop one cycle after that edge. Combinational path from `wen*` to `stall`: none.
- `busy` falls on the edge that enters IDLE with the FIFO empty.

## Structure
- Package `uart_pkg` holds:
  - the FSM state typedef (IDLE, START, DATA, STOP, 2 bits);
  - `UART_DATA_ADDR`;
  - the frame length constant (10 bits).
- Sub-module `sync_fifo_2w1r`: two write ports in fixed order, one read port, and the occupancy count. The FSM, baud counter and shift register stay in `uart_tx_ctrl`.

## Test plan
- **Single byte:** CLK_PER_BIT=4, `wen1` with 0x55 at edge 0.
  - `uart_tx` low for cycles 1–4.
  - Data bits 1,0,1,0,1,0,1,0, 4 cycles each.
  - High for cycles 37–40.
  - `busy` falls at edge 41.
- **Dual write:** same edge, `wen1`=0x41 and `wen2`=0x42.
  - Frames 0x41 then 0x42 back-to-back, 80 cycles total.
  - `count` sequence 2→1 (edge after pop)→0 at the second pop.
- **Lane-2 only:** `wen2`=0xA3 with `wen1`=0 produces a single 0xA3 frame. `overflow` stays 0.
- **Fill and overflow:** DEPTH=16, transmitter stalled mid-frame, 16 single writes.
  - `stall` rises once `count`=15.
  - With `count`=15, a dual write pushes lane 1 only and sets `overflow`.
  - A 17th write is dropped.
- **Reset mid-frame:** `RST` pulsed during bit 3 of a frame with 3 bytes queued.
  - Next cycle: `uart_tx`=1, `count`=0, `busy`=0, `overflow`=0.
  - No further frames.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit controller.
//   uart_state_t   - transmitter FSM state (IDLE, START, DATA, STOP)
//   UART_DATA_ADDR - store address decoded by the core's data-memory lanes
//   FRAME_BITS     - bits per 8N1 frame (start + 8 data + stop)
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam logic [31:0] UART_DATA_ADDR = 32'h1000_0000;
    localparam int          FRAME_BITS     = 10;

endpackage

// File: rtl/sync_fifo_2w1r.sv
// sync_fifo_2w1r: byte FIFO with two ordered write ports and one read port.
//   i_clk, i_rst        - clock, synchronous active-high reset
//   i_wen1, i_wdata1    - older write (always placed first)
//   i_wen2, i_wdata2    - younger write
//   i_pop               - remove head entry (ignored when empty)
//   o_rd_data           - head entry
//   o_empty             - no entries
//   o_drop              - at least one strobed byte was refused this cycle
//   o_count             - current occupancy (registered pointers)
//   o_count_next        - occupancy after this edge's pushes and pop
// Acceptance only looks at the current occupancy; a same-cycle pop never
// frees a slot for a same-cycle write.
module sync_fifo_2w1r #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wen1,
    input  logic [W-1:0]             i_wdata1,
    input  logic                     i_wen2,
    input  logic [W-1:0]             i_wdata2,
    input  logic                     i_pop,
    output logic [W-1:0]             o_rd_data,
    output logic                     o_empty,
    output logic                     o_drop,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [$clog2(DEPTH):0]   o_count_next
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [CW-1:0] r_wr;
    logic [CW-1:0] r_rd;

    logic          w_full;
    logic [CW-1:0] w_count;
    logic [1:0]    w_n_push;
    logic [W-1:0]  w_d_first;
    logic          w_drop;
    logic          w_pop_ok;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_wr_idx1;

    // Extra MSB on the pointers distinguishes full from empty.
    assign w_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_empty   = (r_wr == r_rd);
    assign w_count   = r_wr - r_rd;
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_wr_idx  = r_wr[AW-1:0];
    assign w_wr_idx1 = w_wr_idx + AW'(1);

    always_comb begin
        w_n_push  = 2'd0;
        w_d_first = i_wdata1;
        w_drop    = 1'b0;
        if (i_wen1 && i_wen2) begin
            if (w_count <= CW'(DEPTH - 2)) begin
                w_n_push = 2'd2;
            end else if (!w_full) begin
                // One slot left: the older byte wins, the younger is lost.
                w_n_push = 2'd1;
                w_drop   = 1'b1;
            end else begin
                w_drop   = 1'b1;
            end
        end else if (i_wen1 || i_wen2) begin
            if (i_wen2) w_d_first = i_wdata2;
            if (!w_full) w_n_push = 2'd1;
            else         w_drop   = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            r_wr <= r_wr + CW'(w_n_push);
            if (w_pop_ok) r_rd <= r_rd + CW'(1);
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_n_push != 2'd0) r_mem[w_wr_idx]  <= w_d_first;
        if (w_n_push == 2'd2) r_mem[w_wr_idx1] <= i_wdata2;
    end

    assign o_rd_data    = r_mem[r_rd[AW-1:0]];
    assign o_drop       = w_drop;
    assign o_count      = w_count;
    assign o_count_next = w_count + CW'(w_n_push) - CW'(w_pop_ok);

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: memory-mapped UART transmitter fed by two store lanes.
//   CLK, RST          - clock, synchronous active-high reset
//   wen1/wdata1       - older lane byte store
//   wen2/wdata2       - younger lane byte store
//   stall             - fewer than two free FIFO entries
//   busy              - frame on the line or bytes waiting
//   overflow          - sticky: a byte was dropped since reset
//   count             - FIFO occupancy
//   uart_tx           - 8N1 serial output, idle high
//   dbg_state         - current transmitter FSM state
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 868,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         wen1,
    input  logic [7:0]                   wdata1,
    input  logic                         wen2,
    input  logic [7:0]                   wdata2,
    output logic                         stall,
    output logic                         busy,
    output logic                         overflow,
    output logic [$clog2(FIFO_DEPTH):0]  count,
    output logic                         uart_tx,
    output uart_state_t                  dbg_state
);

    localparam int             BW       = $clog2(CLK_PER_BIT);
    localparam int             CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0]  BAUD_MAX = BW'(CLK_PER_BIT - 1);

    uart_state_t   r_state, w_state_next;
    logic [BW-1:0] r_baud,  w_baud_next;
    logic [2:0]    r_bit,   w_bit_next;
    logic [7:0]    r_shift, w_shift_next;
    logic          r_tx,    w_tx_next;
    logic          r_stall;
    logic          r_ovf;

    logic          w_pop;
    logic [7:0]    w_rd_data;
    logic          w_empty;
    logic          w_drop;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_next;

    sync_fifo_2w1r #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .i_clk        (CLK),
        .i_rst        (RST),
        .i_wen1       (wen1),
        .i_wdata1     (wdata1),
        .i_wen2       (wen2),
        .i_wdata2     (wdata2),
        .i_pop        (w_pop),
        .o_rd_data    (w_rd_data),
        .o_empty      (w_empty),
        .o_drop       (w_drop),
        .o_count      (w_count),
        .o_count_next (w_count_next)
    );

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud + BW'(1);
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_baud_next = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_rd_data;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (r_baud == BAUD_MAX) begin
                    w_baud_next  = '0;
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_baud == BAUD_MAX) begin
                    w_baud_next  = '0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    w_bit_next   = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (r_baud == BAUD_MAX) begin
                    w_baud_next = '0;
                    // Chain straight into the next start bit when more is queued.
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_rd_data;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        // Line level is registered from the next state so uart_tx is glitch-free.
        w_tx_next = 1'b1;
        if (w_state_next == ST_START)     w_tx_next = 1'b0;
        else if (w_state_next == ST_DATA) w_tx_next = w_shift_next[0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_stall <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
            r_stall <= (w_count_next >= CW'(FIFO_DEPTH - 1));
            r_ovf   <= r_ovf | w_drop;
        end
    end

    assign uart_tx   = r_tx;
    assign stall     = r_stall;
    assign overflow  = r_ovf;
    assign count     = w_count;
    assign busy      = (r_state != ST_IDLE) || (w_count != '0);
    assign dbg_state = r_state;

endmodule
